// File: rtl/gray_stamp_decoder_pkg.sv
// Shared definitions for gray_stamp_decoder: FSM state encoding and default width.
package gray_stamp_decoder_pkg;

  // Default width of the Gray input and of every binary result.
  localparam int GSD_SIZE = 8;

  // Decoder control states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/gray_bit_step.sv
// Single Gray-to-binary bit step: a binary bit is the XOR of the next-higher
// binary bit and the Gray bit at the same position.
module gray_bit_step (
  input  logic b_prev,
  input  logic g_bit,
  output logic b_out
);

  // One XOR per decoded bit.
  always_comb begin
    b_out = b_prev ^ g_bit;
  end

endmodule

// File: rtl/gray_stamp_decoder.sv
// gray_stamp_decoder: captures a Gray-coded tick value, decodes it one bit per
// clock (MSB first) and reports the binary value plus the modular distance to
// the previously delivered sample.
//
// Optional feature: define GRAY_DEC_MISS_EN to add the sticky Missed flag that
// records captures dropped while the decoder is busy.
//
// Handshake: a result is transferred on any rising edge where Valid and Ready
// are both high. Valid is high only in HOLD and the result outputs stay stable
// until that edge; Ready has no effect while Valid is low.
module gray_stamp_decoder
  import gray_stamp_decoder_pkg::*;
#(
  parameter int SIZE = GSD_SIZE
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic [SIZE-1:0] Gray_in,
  input  logic            Capture,
  output logic            Busy,
  output logic [SIZE-1:0] Bin_out,
  output logic [SIZE-1:0] Delta,
  output logic            Valid,
  input  logic            Ready,
  output state_t          dbg_state
`ifdef GRAY_DEC_MISS_EN
  ,
  output logic            Missed
`endif
);

  localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;

  state_t            state;
  state_t            state_next;
  logic [SIZE-1:0]   shadow;      // Gray sample being decoded
  logic [SIZE-1:0]   work;        // binary bits decoded so far
  logic [SIZE-1:0]   work_next;   // work with the current bit filled in
  logic [SIZE-1:0]   work_shift;  // work[i+1] presented at position i
  logic [SIZE-1:0]   prev;        // last result handed to the consumer
  logic [IDX_W-1:0]  idx;         // bit position decoded this cycle
  logic              accept;
  logic              last_step;
  logic              handshake;
  logic              step_prev;
  logic              step_g;
  logic              step_out;

  // Next-state and control decode; defaults first.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_step  = 1'b0;
    handshake  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Capture) begin
          accept     = 1'b1;
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (idx == '0) begin
          last_step  = 1'b1;
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (Ready) begin
          handshake = 1'b1;
          if (Capture) begin
            accept     = 1'b1;
            state_next = ST_DECODE;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Operand selection for the current bit. Above the MSB the shifted copy
  // supplies a zero, so the MSB step degenerates to b = g.
  always_comb begin
    work_shift           = {1'b0, work[SIZE-1:1]};
    step_prev            = work_shift[idx];
    step_g               = shadow[idx];
    work_next            = work;
    work_next[idx]       = step_out;
  end

  gray_bit_step u_step (
    .b_prev (step_prev),
    .g_bit  (step_g),
    .b_out  (step_out)
  );

  // State register and datapath; the bit-0 result is forwarded straight
  // into Bin_out/Delta at the same edge it is computed.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state   <= ST_IDLE;
      shadow  <= '0;
      work    <= '0;
      idx     <= '0;
      prev    <= '0;
      Bin_out <= '0;
      Delta   <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        shadow <= Gray_in;
        work   <= '0;
        idx    <= IDX_W'(SIZE - 1);
      end else if (state == ST_DECODE) begin
        work <= work_next;
        if (idx != '0) begin
          idx <= idx - IDX_W'(1);
        end
      end
      if (last_step) begin
        Bin_out <= work_next;
        Delta   <= work_next - prev;
      end
      if (handshake) begin
        prev <= Bin_out;
      end
    end
  end

  // Status outputs decoded from the state register.
  always_comb begin
    Busy      = (state != ST_IDLE);
    Valid     = (state == ST_HOLD);
    dbg_state = state;
  end

`ifdef GRAY_DEC_MISS_EN
  logic drop;

  // A capture is dropped while decoding or while a result waits for Ready.
  always_comb begin
    drop = Capture && ((state == ST_DECODE) || ((state == ST_HOLD) && !Ready));
  end

  // Sticky flag: set on any drop, cleared by the handshake.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      Missed <= 1'b0;
    end else if (drop) begin
      Missed <= 1'b1;
    end else if (handshake) begin
      Missed <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_gray_stamp_decoder.sv
// Testbench for gray_stamp_decoder: directed sequence with literal results,
// then randomized traffic checked every cycle against a behavioural model.
module tb_gray_stamp_decoder;
  import gray_stamp_decoder_pkg::*;

  localparam int SIZE = 8;

  logic            Clk;
  logic            Rst_n;
  logic [SIZE-1:0] Gray_in;
  logic            Capture;
  logic            Busy;
  logic [SIZE-1:0] Bin_out;
  logic [SIZE-1:0] Delta;
  logic            Valid;
  logic            Ready;
  state_t          dbg_state;
`ifdef GRAY_DEC_MISS_EN
  logic            Missed;
`endif

  gray_stamp_decoder #(.SIZE(SIZE)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Gray_in   (Gray_in),
    .Capture   (Capture),
    .Busy      (Busy),
    .Bin_out   (Bin_out),
    .Delta     (Delta),
    .Valid     (Valid),
    .Ready     (Ready),
    .dbg_state (dbg_state)
`ifdef GRAY_DEC_MISS_EN
    ,
    .Missed    (Missed)
`endif
  );

  // ---------------- clock ----------------
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // ---------------- scoreboard counters ----------------
  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;
  logic [SIZE-1:0] exp_q[$];   // expected Bin_out values of results still to come

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Gray to binary by prefix XOR of all higher Gray bits.
  function automatic logic [SIZE-1:0] g2b(input logic [SIZE-1:0] g);
    logic [SIZE-1:0] b;
    b = g;
    for (int s = 1; s < SIZE; s = s * 2) b = b ^ (b >> s);
    return b;
  endfunction

  int              m_cnt   = 0;     // decode edges still to go
  logic            m_valid = 1'b0;
  logic [SIZE-1:0] m_g     = '0;
  logic [SIZE-1:0] m_bin   = '0;
  logic [SIZE-1:0] m_delta = '0;
  logic [SIZE-1:0] m_prev  = '0;
  logic            m_missed = 1'b0;

  always @(posedge Clk) begin
    if (!Rst_n) begin
      m_cnt <= 0; m_valid <= 1'b0; m_g <= '0; m_bin <= '0;
      m_delta <= '0; m_prev <= '0; m_missed <= 1'b0;
    end else if (m_valid) begin
      if (Ready) begin
        m_prev   <= m_bin;
        m_valid  <= 1'b0;
        m_missed <= 1'b0;
        if (Capture) begin
          m_g   <= Gray_in;
          m_cnt <= SIZE;
        end
      end else if (Capture) begin
        m_missed <= 1'b1;
      end
    end else if (m_cnt > 0) begin
      if (Capture) m_missed <= 1'b1;
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_bin   <= g2b(m_g);
        m_delta <= g2b(m_g) - m_prev;
        m_valid <= 1'b1;
      end
    end else if (Capture) begin
      m_g   <= Gray_in;
      m_cnt <= SIZE;
    end
  end

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(negedge Clk);
      if (chk_en) begin
        check("busy",  32'(Busy),    32'(m_cnt > 0 || m_valid));
        check("valid", 32'(Valid),   32'(m_valid));
        check("bin",   32'(Bin_out), 32'(m_bin));
        check("delta", 32'(Delta),   32'(m_delta));
`ifdef GRAY_DEC_MISS_EN
        check("missed", 32'(Missed), 32'(m_missed));
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_capture(input logic [SIZE-1:0] g);
    Capture = 1'b1;
    Gray_in = g;
    @(negedge Clk);
    Capture = 1'b0;
    Gray_in = SIZE'($urandom);
  endtask

  // Waits for Valid (one negedge already elapsed in do_capture), then checks
  // latency and the result against literal values.
  task automatic wait_result(input string name, input logic [SIZE-1:0] eb, input logic [SIZE-1:0] ed);
    int n;
    logic [SIZE-1:0] qb;
    n = 1;
    while (!Valid && n < 60) begin
      @(negedge Clk);
      n++;
    end
    check({name, "_timeout"}, 32'(Valid), 32'd1);
    check({name, "_latency"}, 32'(n), 32'(SIZE + 1));
    qb = exp_q.pop_front();
    check({name, "_bin"}, 32'(Bin_out), 32'(qb));
    check({name, "_bin_lit"}, 32'(Bin_out), 32'(eb));
    check({name, "_delta_lit"}, 32'(Delta), 32'(ed));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    Rst_n   = 1'b0;
    Capture = 1'b0;
    Ready   = 1'b0;
    Gray_in = '0;
    repeat (2) @(negedge Clk);
    chk_en = 1'b1;
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_bin",   32'(Bin_out),   32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    Ready = 1'b1;

    // Model pins: expected binary values from the closed-form decoder.
    exp_q.push_back(g2b(8'hC0));
    exp_q.push_back(g2b(8'h80));
    exp_q.push_back(g2b(8'h01));
    exp_q.push_back(g2b(8'h02));
    exp_q.push_back(g2b(8'h03));

    do_capture(8'hC0);
    wait_result("first", 8'h80, 8'h80);
    @(negedge Clk);
    check("after_hs_valid", 32'(Valid), 32'd0);

    do_capture(8'h80);
    wait_result("second", 8'hFF, 8'h7F);
    @(negedge Clk);

    do_capture(8'h01);
    wait_result("wrap", 8'h01, 8'h02);
    @(negedge Clk);

    // Stall in HOLD with capture pulses.
    Ready = 1'b0;
    do_capture(8'h02);
    wait_result("stall", 8'h03, 8'h02);
    for (int i = 0; i < 20; i++) begin
      Capture = (i % 2 == 0);
      Gray_in = SIZE'($urandom);
      @(negedge Clk);
      check("stall_valid", 32'(Valid), 32'd1);
      check("stall_bin", 32'(Bin_out), 32'h03);
    end
`ifdef GRAY_DEC_MISS_EN
    check("stall_missed", 32'(Missed), 32'd1);
`endif

    // Handshake with a simultaneous capture goes straight to DECODE.
    Ready = 1'b1;
    do_capture(8'h03);
    check("hs_cap_valid", 32'(Valid), 32'd0);
    check("hs_cap_busy", 32'(Busy), 32'd1);
`ifdef GRAY_DEC_MISS_EN
    check("hs_cap_missed", 32'(Missed), 32'd0);
`endif
    wait_result("hs_cap", 8'h02, 8'hFF);
    @(negedge Clk);

    // Reset during the fourth DECODE cycle.
    do_capture(8'h55);
    repeat (3) @(negedge Clk);
    Rst_n = 1'b0;
    @(negedge Clk);
    check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("midrst_busy",  32'(Busy),      32'd0);
    check("midrst_bin",   32'(Bin_out),   32'd0);
    check("midrst_delta", 32'(Delta),     32'd0);
    Rst_n = 1'b1;
    exp_q.push_back(g2b(8'h0F));
    do_capture(8'h0F);
    wait_result("post_rst", 8'h0A, 8'h0A);
    @(negedge Clk);

    // Randomized traffic, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      Rst_n   = ($urandom_range(0, 299) != 0);
      Capture = ($urandom_range(0, 3) == 0);
      Ready   = ($urandom_range(0, 2) != 0);
      Gray_in = SIZE'($urandom);
      @(negedge Clk);
    end
    Rst_n   = 1'b1;
    Capture = 1'b0;
    Ready   = 1'b1;
    repeat (SIZE + 4) @(negedge Clk);
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gray_stamp_decoder.md
# gray_stamp_decoder

Consumer-side companion to the Gray-code timer. Samples a Gray-coded tick value on a capture strobe, decodes it serially (one bit per clock, MSB first) to binary, and computes the modular elapsed ticks since the previously delivered sample. Results leave through a Valid/Ready handshake towards the test-register FSM that logs decay and upslope measurements.

## Interface
- `SIZE`, 8: width of the Gray input and of all binary results; valid range ≥ 2.
- `Clk` input 1: clock reference; all state updates on the rising edge.
- `Rst_n` input 1: reset, synchronous, active low; sampled on the rising edge of `Clk`.
- `Gray_in` input SIZE: Gray-coded tick value; sampled only when a capture is accepted.
- `Capture` input 1: capture strobe, one-cycle pulse or level; sampled every cycle.
- `Busy` output 1: high in DECODE and HOLD.
- `Bin_out` output SIZE: decoded binary value of the last accepted capture.
- `Delta` output SIZE: `(Bin_out - prev) mod 2^SIZE`.
- `Valid` output 1: result available; high only in HOLD.
- `Ready` input 1: consumer accepts the result when `Valid` and `Ready` are both high on an edge.
- `Missed` output 1: sticky dropped-capture flag; exists only with `GRAY_DEC_MISS_EN`.

## Operation
- Reset: `Rst_n`=0 at an edge sets the state to IDLE and clears `Busy`, `Valid`, `Bin_out`, `Delta`, `Missed`, the internal `prev` register, the Gray shadow register and the bit index. Reset overrides everything, including mid-DECODE and mid-HOLD, and discards any partial result.
- IDLE:
  - `Capture`=1 latches `Gray_in` into the shadow register, sets the bit index to SIZE-1 and moves to DECODE.
- DECODE, one bit per cycle:
  - The MSB step sets `b[SIZE-1] = g[SIZE-1]`.
  - Each later step sets `b[i] = b[i+1] ^ g[i]`.
  - After the bit-0 step: load `Bin_out` and `Delta` at that same edge, then move to HOLD.
  - `Bin_out` holds the previous result until this load.
- HOLD: `Valid`=1 and outputs are stable until the handshake.
  - On `Valid`&&`Ready`: `prev` <= `Bin_out`.
  - If `Capture`=1 in the same cycle, latch `Gray_in` and go directly to DECODE; otherwise go to IDLE.
- `Capture` in DECODE, or in HOLD without `Ready`, is ignored. The capture is never queued.
- First result after reset has `prev`=0, so `Delta`=`Bin_out`.
- Arithmetic:
  - `Delta` is an unsigned SIZE-bit subtraction; carry and borrow are discarded.
  - A wrap of the timer between samples gives the correct modular distance.
  - Equal samples give `Delta`=0.

## Timing
- Capture sampled at edge E0 gives `Valid`=1 after edge E0+SIZE, i.e. SIZE+1 cycles of latency.
- `Busy` rises after E0.
- Back-to-back throughput is one result per SIZE+1 cycles when `Ready` is held high and `Capture` is present at each handshake.
- `Valid` falls on the cycle after the handshake edge.
- `Ready` without `Valid` has no effect.

## Configuration
- `GRAY_DEC_MISS_EN` defined:
  - `Missed` port present.
  - Set at any edge where `Capture`=1 is ignored.
  - Reported alongside `Valid`.
  - Cleared at the handshake edge, unless a dropped capture occurs at that same edge, in which case it stays set.
  - Reset value 0.
- `GRAY_DEC_MISS_EN` undefined: port and logic are absent; dropped captures are silent.

## Structure
- Shared package/include holds:
  - state encoding constants `ST_IDLE`, `ST_DECODE`, `ST_HOLD`;
  - default `SIZE`.
- One sub-module is natural: `gray_bit_step`, the combinational single-bit step `b_out = b_prev ^ g_bit`, reused for the final-bit forward path.
- No other hierarchy.

## Test plan
- Reset, then capture `Gray_in`=8'hC0 with `Ready`=1 -> after 9 cycles `Valid`=1, `Bin_out`=8'h80, `Delta`=8'h80.
- Next capture `Gray_in`=8'h80 -> `Bin_out`=8'hFF, `Delta`=8'h7F.
- Wrap: next capture `Gray_in`=8'h01 -> `Bin_out`=8'h01, `Delta`=8'h02.
- `Ready`=0 for 20 cycles in HOLD while pulsing `Capture` -> outputs stable, no new decode, `Missed`=1 (macro on). On `Ready` the handshake completes and `Missed` clears.
- Handshake cycle with `Capture`=1 and `Gray_in`=8'h03 -> DECODE entered directly, next `Valid` 9 cycles later with `Bin_out`=8'h02.
- `Rst_n`=0 on the fourth DECODE cycle -> next cycle all outputs 0, state IDLE. The next result has `Delta`=`Bin_out`.
